conv_line_sched: RTL and testbench

Sequencer for the 3x3 convolution path. It accepts a raster-order 8-bit pixel stream of one frame and routes each pixel into one of three rotating line buffers. It issues a window strobe to the convolution unit whenever a full 3x3 neighbourhood is available, and tracks outstanding results until the frame is finished. It sits between the pixel source and the FIFO/convolution datapath, and drives the `idle`/`done` status that sources poll.

---
 rtl/conv_line_sched_if.sv | 42 ++++
 rtl/conv_line_sched.sv | 160 ++++++++++++++++
 tb/tb_conv_line_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_line_sched_if.sv
// -----------------------------------------------------------------------------
// conv_line_sched_if
// Bundles the pixel stream, the line buffer write port, the window strobe and
// the convolution completion pulse used by conv_line_sched.
//
// Handshake: a pixel moves from source to controller on a rising clk edge
// where data_valid && data_ready are both high. data_ready never depends
// combinationally on data_valid. The source holds data_i stable while
// data_valid is high and not yet accepted.
//
// Modports:
//   master : pixel source / convolution side (drives data_valid, data_i,
//            conv_done; observes everything else)
//   slave  : conv_line_sched controller
// Parameter CW : width of win_x / win_y.
// -----------------------------------------------------------------------------
interface conv_line_sched_if #(
  parameter int CW = 8
);
  logic          data_valid;
  logic [7:0]    data_i;
  logic          data_ready;
  logic [2:0]    line_wr_en;
  logic [7:0]    line_wr_data;
  logic          win_valid;
  logic [1:0]    top_sel;
  logic [CW-1:0] win_x;
  logic [CW-1:0] win_y;
  logic          conv_done;

  modport master (
    output data_valid, data_i, conv_done,
    input  data_ready, line_wr_en, line_wr_data, win_valid, top_sel,
           win_x, win_y
  );

  modport slave (
    input  data_valid, data_i, conv_done,
    output data_ready, line_wr_en, line_wr_data, win_valid, top_sel,
           win_x, win_y
  );
endinterface

// File: rtl/conv_line_sched.sv
// -----------------------------------------------------------------------------
// conv_line_sched
// Sequencer for the 3x3 convolution path. Routes a raster-order pixel stream
// into three rotating line buffers, strobes a window whenever a full 3x3
// neighbourhood is present and tracks unanswered windows until frame end.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : frame start request (honoured only in IDLE)
//   idle         : controller in IDLE
//   done         : one-cycle frame-complete pulse
//   dbg_state    : current FSM state (IDLE=0, RUN=1, WAIT=2, DONE=3)
//   dbg_issued   : windows issued in the current frame
//   bus          : conv_line_sched_if.slave (pixel stream, line buffer write,
//                  window strobe, conv_done)
//
// Optional feature: define CONV_STRIDE2_EN to issue windows only at even
// offsets from the first full neighbourhood (stride 2). Default is stride 1.
// -----------------------------------------------------------------------------
module conv_line_sched #(
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int CW      = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             idle,
  output logic             done,
  output logic [1:0]       dbg_state,
  output logic [2*CW-1:0]  dbg_issued,
  conv_line_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int            OW       = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t          state, next_state;
  logic [CW-1:0]   col, row;
  logic [1:0]      wr_sel;
  logic [OW-1:0]   outstanding, outstanding_next;
  logic [2*CW-1:0] issued;

  logic accept, win_hit, issue, dec, start_frame, last_pix;

  assign accept      = bus.data_valid && bus.data_ready;
  assign start_frame = (state == S_IDLE) && start;
  assign last_pix    = accept && (col == COL_LAST) && (row == ROW_LAST);

`ifdef CONV_STRIDE2_EN
  // col-2 / row-2 even is the same as col / row even.
  assign win_hit = (row >= TWO) && (col >= TWO) && !col[0] && !row[0];
`else
  assign win_hit = (row >= TWO) && (col >= TWO);
`endif

  assign issue = accept && win_hit;
  // A completion with nothing outstanding is spurious and dropped.
  assign dec   = bus.conv_done && (outstanding != '0);

  always_comb begin
    outstanding_next = outstanding;
    case ({issue, dec})
      2'b10:   outstanding_next = outstanding + OW'(1);
      2'b01:   outstanding_next = outstanding - OW'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (last_pix) next_state = S_WAIT;
      // Uses the post-update count so a same-cycle conv_done can finish.
      S_WAIT:  if (outstanding_next == '0) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    idle           = (state == S_IDLE);
    done           = (state == S_DONE);
    bus.data_ready = (state == S_RUN) && (outstanding < OUT_MAX);
    dbg_state      = state;
    dbg_issued     = issued;
  end

  // ---------------- position and bookkeeping counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      wr_sel      <= '0;
      outstanding <= '0;
      issued      <= '0;
    end else if (start_frame) begin
      col         <= '0;
      row         <= '0;
      wr_sel      <= '0;
      outstanding <= '0;
      issued      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (issue) issued <= issued + 1'b1;
      if (accept) begin
        if (col == COL_LAST) begin
          col    <= '0;
          row    <= row + 1'b1;
          wr_sel <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // ---------------- registered datapath strobes ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.line_wr_en   <= '0;
      bus.line_wr_data <= '0;
      bus.win_valid    <= 1'b0;
      bus.top_sel      <= '0;
      bus.win_x        <= '0;
      bus.win_y        <= '0;
    end else begin
      bus.line_wr_en <= accept ? (3'b001 << wr_sel) : 3'b000;
      if (accept) bus.line_wr_data <= bus.data_i;
      bus.win_valid <= issue;
      if (issue) begin
        // Oldest row lives in the buffer written after the current one.
        bus.top_sel <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
        bus.win_x   <= col - 1'b1;
        bus.win_y   <= row - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_line_sched.sv
module tb_conv_line_sched;
  localparam int W       = 5;
  localparam int H       = 5;
  localparam int CW      = 8;
  localparam int MAX_OUT = 4;
  localparam int XW      = 2 + 2 * CW;
`ifdef CONV_STRIDE2_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 9;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic idle, done;
  logic [1:0]      dbg_state;
  logic [2*CW-1:0] dbg_issued;

  always #5 clk = ~clk;

  conv_line_sched_if #(.CW(CW)) bus ();

  conv_line_sched #(
    .IMG_W(W), .IMG_H(H), .CW(CW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .idle(idle),
    .done(done),
    .dbg_state(dbg_state),
    .dbg_issued(dbg_issued),
    .bus(bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [XW-1:0] exp_q[$];
  logic [10:0]   line_q[$];
  int due_q[$];
  int cyc       = 0;
  int lat       = 2;
  bit resp_en   = 1'b1;
  int inj_cnt   = 0;
  int inj_seen  = 0;
  bit conv_is_inj = 1'b0;
  int ans_cnt   = 0;
  int done_cnt  = 0;
  int iss_m     = 0;
  int ans_base  = 0;
  int done_base = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Reference rule: a window centred at (x-1,y-1) exists once pixel (x,y)
  // completes a 3x3 block; its top row y-2 sits in buffer (y-2) mod 3.
  function automatic bit win_at(input int x, input int y);
`ifdef CONV_STRIDE2_EN
    return (x >= 2) && (y >= 2) && ((x - 2) % 2 == 0) && ((y - 2) % 2 == 0);
`else
    return (x >= 2) && (y >= 2);
`endif
  endfunction

  // ---------------- conv_done responder ----------------
  initial begin
    bus.conv_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.conv_done = 1'b0;
      conv_is_inj   = 1'b0;
      if (inj_cnt != inj_seen) begin
        bus.conv_done = 1'b1;
        conv_is_inj   = 1'b1;
        inj_seen++;
      end else if (resp_en && due_q.size() > 0 && due_q[0] <= cyc) begin
        bus.conv_done = 1'b1;
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.win_valid) begin
          due_q.push_back(cyc + lat);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL win_unexpected: got %0h want none", {bus.top_sel, bus.win_x, bus.win_y});
          end else begin
            check("window", {bus.top_sel, bus.win_x, bus.win_y}, exp_q.pop_front());
          end
        end
        if (bus.line_wr_en != 3'b000) begin
          if (line_q.size() == 0) begin
            total++; bad++;
            $display("FAIL line_unexpected: got %0h want none", {bus.line_wr_en, bus.line_wr_data});
          end else begin
            check("line_write", {bus.line_wr_en, bus.line_wr_data}, line_q.pop_front());
          end
        end
        if (bus.conv_done && !conv_is_inj) ans_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    iss_m     = 0;
    ans_base  = ans_cnt;
    done_base = done_cnt;
    check("idle_in_run", idle, 1'b0);
  endtask

  task automatic send_pixel(input int idx, input logic [7:0] d, input bit start_too);
    int  x = idx % W;
    int  y = idx / W;
    int  waited = 0;
    bit  acc = 1'b0;
    bit  exp_rdy;
    bus.data_valid = 1'b1;
    bus.data_i     = d;
    start          = start_too;
    while (!acc) begin
      exp_rdy = ((iss_m - (ans_cnt - ans_base)) < MAX_OUT);
      check("data_ready", bus.data_ready, exp_rdy);
      if (bus.data_ready) begin
        acc = 1'b1;
        line_q.push_back({3'(1 << (y % 3)), d});
        if (win_at(x, y)) begin
          exp_q.push_back({2'((y - 2) % 3), CW'(x - 1), CW'(y - 1)});
          iss_m++;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (!acc) begin
        waited++;
        if (waited > 60) begin
          total++; bad++;
          $display("FAIL pixel_timeout: got no accept want accept of pixel %0d", idx);
          acc = 1'b1;
        end
      end
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic finish_frame();
    bus.data_valid = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
    end
    check("done_seen", done, 1'b1);
    check("all_answered", ans_cnt - ans_base, iss_m);
    check("issued_count", dbg_issued, NWIN);
    check("win_q_empty", exp_q.size(), 0);
    check("line_q_empty", line_q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", idle, 1'b1);
    check("ready_in_idle", bus.data_ready, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("done_pulses", done_cnt - done_base, 1);
  endtask

  // gap: 0 continuous, 1 every other cycle, 2 random idle cycles
  task automatic run_frame(input int gap, input bit rnd_data, input int inj_at, input int start_at);
    logic [7:0] d;
    do_start();
    for (int i = 0; i < W * H; i++) begin
      d = rnd_data ? 8'($urandom) : 8'(i);
      if (i == inj_at) inj_cnt++;
      send_pixel(i, d, i == start_at);
      if (gap == 1) begin @(posedge clk); #1; end
      if (gap == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    finish_frame();
  endtask

  task automatic hold_frame();
    bit held = 1'b0;
    resp_en = 1'b0;
    do_start();
    for (int i = 0; i < W * H; i++) begin
      if (!held && (iss_m - (ans_cnt - ans_base)) >= MAX_OUT) begin
        bus.data_valid = 1'b1;
        bus.data_i     = 8'(i);
        repeat (6) begin
          check("stall_ready", bus.data_ready, 1'b0);
          @(posedge clk); #1;
        end
        bus.data_valid = 1'b0;
        held    = 1'b1;
        resp_en = 1'b1;
      end
      send_pixel(i, 8'(i), 1'b0);
    end
    resp_en = 1'b1;
    finish_frame();
  endtask

  task automatic reset_frame();
    do_start();
    for (int i = 0; i <= 12; i++) send_pixel(i, 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_ready", bus.data_ready, 1'b0);
    check("rst_wr_en", bus.line_wr_en, 3'b000);
    check("rst_wr_data", bus.line_wr_data, 8'h00);
    check("rst_win_valid", bus.win_valid, 1'b0);
    check("rst_top_sel", bus.top_sel, 2'd0);
    check("rst_win_x", bus.win_x, 0);
    check("rst_win_y", bus.win_y, 0);
    check("rst_done", done, 1'b0);
    check("rst_idle", idle, 1'b1);
    exp_q.delete();
    line_q.delete();
    due_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", idle, 1'b1);
    run_frame(0, 1'b0, -1, -1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.data_valid = 1'b0;
    bus.data_i     = 8'h00;
    #12;
    check("reset_idle", idle, 1'b1);
    check("reset_ready", bus.data_ready, 1'b0);
    check("reset_win_valid", bus.win_valid, 1'b0);
    check("reset_wr_en", bus.line_wr_en, 3'b000);
    check("reset_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    lat = 2;
    run_frame(0, 1'b0, -1, -1);   // continuous stream
    hold_frame();                 // backpressure with conv_done withheld
    run_frame(1, 1'b0, -1, -1);   // data_valid every other cycle
    run_frame(0, 1'b1, 3, 8);     // stray conv_done and start during RUN
    reset_frame();                // reset mid-frame, then clean frame
    for (int f = 0; f < 3; f++) begin
      lat = $urandom_range(1, 6);
      run_frame(2, 1'b1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
